// File: rtl/zcu111_axis_pkg.sv
// Shared AXI4-Stream definitions for the ZCU111 ADC/DAC datapath blocks.
// Sample/beat widths and the 2:1 unpacker state encoding.
package zcu111_axis_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int ADC_BEAT_W = 128;
    localparam int DAC_BEAT_W = 256;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        UNPK_EMPTY,
        UNPK_FIRST,
        UNPK_SECOND
    } unpack_state_t;

endpackage

// File: rtl/dac_xfer_unpack_x2.sv
// 2:1 AXI4-Stream width-halving unpacker: one IN_WIDTH beat in, two half beats out.
// Optional tlast pass-through (on the second half) when DAC_UNPACK_TLAST_EN is defined.
module dac_xfer_unpack_x2
    import zcu111_axis_pkg::*;
#(
    parameter int IN_WIDTH  = DAC_BEAT_W,
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [IN_WIDTH-1:0]   s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
`ifdef DAC_UNPACK_TLAST_EN
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tlast,
`endif
    output logic [IN_WIDTH/2-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    localparam int OUT_WIDTH = IN_WIDTH / 2;

    if ((IN_WIDTH % (2 * SAMPLE_W)) != 0) begin : g_width_check
        $error("IN_WIDTH must split into two whole-sample halves");
    end

    unpack_state_t         state_q;
    unpack_state_t         state_d;
    logic                  load;
    logic [IN_WIDTH-1:0]   hold_q;
    logic [OUT_WIDTH-1:0]  first_half;
    logic [OUT_WIDTH-1:0]  second_half;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= UNPK_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A load in SECOND only happens alongside the draining m handshake, so no bubble.
    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        case (state_q)
            UNPK_EMPTY: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    load    = 1'b1;
                    state_d = UNPK_FIRST;
                end
            end
            UNPK_FIRST: begin
                m_axis_tvalid = 1'b1;
                if (m_axis_tready) begin
                    state_d = UNPK_SECOND;
                end
            end
            UNPK_SECOND: begin
                m_axis_tvalid = 1'b1;
                s_axis_tready = m_axis_tready;
                if (m_axis_tready) begin
                    if (s_axis_tvalid) begin
                        load    = 1'b1;
                        state_d = UNPK_FIRST;
                    end else begin
                        state_d = UNPK_EMPTY;
                    end
                end
            end
            default: begin
                state_d = UNPK_EMPTY;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            hold_q <= '0;
        end else if (load) begin
            hold_q <= s_axis_tdata;
        end
    end

    assign first_half  = LOW_FIRST ? hold_q[OUT_WIDTH-1:0] : hold_q[IN_WIDTH-1:OUT_WIDTH];
    assign second_half = LOW_FIRST ? hold_q[IN_WIDTH-1:OUT_WIDTH] : hold_q[OUT_WIDTH-1:0];

    // Output comes only from hold_q; no combinational path from the slave side.
    assign m_axis_tdata = (state_q == UNPK_SECOND) ? second_half : first_half;

`ifdef DAC_UNPACK_TLAST_EN
    logic tlast_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tlast_q <= 1'b0;
        end else if (load) begin
            tlast_q <= s_axis_tlast;
        end
    end

    assign m_axis_tlast = (state_q == UNPK_SECOND) & tlast_q;
`endif

endmodule

// File: tb/tb_dac_xfer_unpack_x2.sv
// Bench for dac_xfer_unpack_x2: LOW_FIRST=1 and LOW_FIRST=0 instances share one stimulus
// and are checked against a queue-of-half-beats reference model.
module tb_dac_xfer_unpack_x2;

    localparam int IW = 256;
    localparam int OW = 128;

    logic          aclk = 1'b0;
    logic          areset;
    logic [IW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          m_tready;
    logic          s_tready_lo, s_tready_hi;
    logic          m_tvalid_lo, m_tvalid_hi;
    logic [OW-1:0] m_tdata_lo, m_tdata_hi;
    logic          m_tlast_lo, m_tlast_hi;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [OW-1:0] lo;
        logic [OW-1:0] hi;
        logic          last;
    } half_t;

    half_t exp_q[$];

    always #5 aclk = ~aclk;

    dac_xfer_unpack_x2 #(.IN_WIDTH(IW), .LOW_FIRST(1'b1)) dut_lo (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready_lo),
`ifdef DAC_UNPACK_TLAST_EN
        .s_axis_tlast  (s_tlast),
        .m_axis_tlast  (m_tlast_lo),
`endif
        .m_axis_tdata  (m_tdata_lo),
        .m_axis_tvalid (m_tvalid_lo),
        .m_axis_tready (m_tready)
    );

    dac_xfer_unpack_x2 #(.IN_WIDTH(IW), .LOW_FIRST(1'b0)) dut_hi (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready_hi),
`ifdef DAC_UNPACK_TLAST_EN
        .s_axis_tlast  (s_tlast),
        .m_axis_tlast  (m_tlast_hi),
`endif
        .m_axis_tdata  (m_tdata_hi),
        .m_axis_tvalid (m_tvalid_hi),
        .m_axis_tready (m_tready)
    );

`ifndef DAC_UNPACK_TLAST_EN
    assign m_tlast_lo = 1'b0;
    assign m_tlast_hi = 1'b0;
`endif

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] ramp_beat(input int base);
        logic [IW-1:0] b;
        for (int i = 0; i < 16; i++) b[i*16 +: 16] = 16'(base + i);
        return b;
    endfunction

    function automatic logic [IW-1:0] rand_beat();
        logic [IW-1:0] b;
        for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Compare every output against the model's view of the queue.
    task automatic check_outputs(input string tag);
        logic          ev;
        logic          er;
        ev = (exp_q.size() != 0);
        er = (exp_q.size() == 0) || (exp_q.size() == 1 && m_tready);
        chk({tag, ".tvalid_lo"}, OW'(m_tvalid_lo), OW'(ev));
        chk({tag, ".tvalid_hi"}, OW'(m_tvalid_hi), OW'(ev));
        chk({tag, ".tready_lo"}, OW'(s_tready_lo), OW'(er));
        chk({tag, ".tready_hi"}, OW'(s_tready_hi), OW'(er));
        if (ev) begin
            chk({tag, ".tdata_lo"}, m_tdata_lo, exp_q[0].lo);
            chk({tag, ".tdata_hi"}, m_tdata_hi, exp_q[0].hi);
`ifdef DAC_UNPACK_TLAST_EN
            chk({tag, ".tlast_lo"}, OW'(m_tlast_lo), OW'(exp_q[0].last));
            chk({tag, ".tlast_hi"}, OW'(m_tlast_hi), OW'(exp_q[0].last));
`endif
        end
    endtask

    // One clock: drive, check mid-cycle, then advance the model on the edge.
    task automatic step(input string tag, input logic sv, input logic [IW-1:0] sd,
                        input logic sl, input logic mr);
        logic ready_pred;
        logic m_hs;
        half_t h;
        s_tvalid = sv;
        s_tdata  = sd;
        s_tlast  = sl;
        m_tready = mr;
        @(negedge aclk);
        check_outputs(tag);
        ready_pred = (exp_q.size() == 0) || (exp_q.size() == 1 && mr);
        m_hs       = (exp_q.size() != 0) && mr;
        @(posedge aclk);
        if (m_hs) void'(exp_q.pop_front());
        if (sv && ready_pred) begin
            h.lo = sd[OW-1:0];  h.hi = sd[IW-1:OW]; h.last = 1'b0;
            exp_q.push_back(h);
            h.lo = sd[IW-1:OW]; h.hi = sd[OW-1:0];  h.last = sl;
            exp_q.push_back(h);
        end
        #1;
    endtask

    int m_count;
    logic [IW-1:0] beat;

    initial begin
        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("reset.tvalid", OW'(m_tvalid_lo), '0);
        chk("reset.tready", OW'(s_tready_lo), OW'(1));
        chk("reset.tdata_lo", m_tdata_lo, '0);
        chk("reset.tdata_hi", m_tdata_hi, '0);
        chk("reset.tlast", OW'(m_tlast_lo), '0);
        areset = 1'b0;

        // Single ramp beat, then drain.
        step("single.load", 1'b1, ramp_beat(0), 1'b0, 1'b1);
        chk("single.first_lo", m_tdata_lo, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        chk("single.first_hi", m_tdata_hi, 128'h000F_000E_000D_000C_000B_000A_0009_0008);
        step("single.h0", 1'b0, '0, 1'b0, 1'b1);
        chk("single.second_lo", m_tdata_lo, 128'h000F_000E_000D_000C_000B_000A_0009_0008);
        chk("single.second_hi", m_tdata_hi, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        step("single.h1", 1'b0, '0, 1'b0, 1'b1);
        step("single.idle", 1'b0, '0, 1'b0, 1'b1);

        // Streaming: offer a new beat every cycle until 8 are accepted.
        m_count = 0;
        for (int b = 0; b < 8; ) begin
            beat = ramp_beat(16 * (b + 1));
            if (s_tready_lo) b++;
            step("stream", 1'b1, beat, 1'b0, 1'b1);
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            if (m_tvalid_lo) m_count++;
            step("stream.drain", 1'b0, '0, 1'b0, 1'b1);
        end
        chk("stream.drained", OW'(exp_q.size()), '0);

        // Backpressure in FIRST for 5 cycles, with a waiting beat offered.
        step("bp.load", 1'b1, rand_beat(), 1'b0, 1'b0);
        beat = rand_beat();
        for (int i = 0; i < 5; i++) step("bp.hold", 1'b1, beat, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step("bp.resume", 1'b0, '0, 1'b0, 1'b1);

        // Asynchronous reset while in SECOND.
        step("rst.load", 1'b1, rand_beat(), 1'b0, 1'b1);
        step("rst.first", 1'b0, '0, 1'b0, 1'b1);
        areset = 1'b1;
        #1;
        chk("rst.tvalid_async", OW'(m_tvalid_lo), '0);
        chk("rst.tready_async", OW'(s_tready_lo), OW'(1));
        exp_q.delete();
        @(posedge aclk);
        #1;
        areset = 1'b0;
        beat = rand_beat();
        step("rst.newload", 1'b1, beat, 1'b0, 1'b1);
        chk("rst.new_first", m_tdata_lo, beat[OW-1:0]);
        step("rst.h0", 1'b0, '0, 1'b0, 1'b1);
        step("rst.h1", 1'b0, '0, 1'b0, 1'b1);

`ifdef DAC_UNPACK_TLAST_EN
        // Three-beat packet, tlast on the third input beat.
        for (int b = 0; b < 3; ) begin
            beat = rand_beat();
            if (s_tready_lo) b++;
            step("tlast.in", 1'b1, beat, (b == 3), 1'b1);
        end
        for (int i = 0; i < 4; i++) step("tlast.drain", 1'b0, '0, 1'b0, 1'b1);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 1)), rand_beat(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) step("rand.drain", 1'b0, '0, 1'b0, 1'b1);
        chk("rand.drained", OW'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
